cnn_line_delay: RTL and testbench
=================================

CNN_LINE_DELAY -- requirements
Module: cnn_line_delay

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 128, width of one delayed word.
- MAX_DEPTH, 30, number of physical stages.
- LEN_W, $clog2(MAX_DEPTH+1), width of the length and count fields.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, clock, rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- clear, input, 1, synchronous flush plus length load.
- cfg_len, input, LEN_W, requested delay in accepted words.
- in_valid, input, 1, in_data accepted and line advances this cycle.
- in_data, input, DATA_W, word to push.
- out_data, output, DATA_W, word pushed len_q accepts ago.
- out_valid, output, 1, out_data holds real data.
- fill_cnt, output, LEN_W, words currently held, saturating at len_q.
- cfg_err, output, 1, sticky illegal-length flag.
- mid_data, output, DATA_W, half-depth tap; present only with LINE_DELAY_MIDTAP_EN.

Function
REQ-003 Storage SHALL be MAX_DEPTH registers stage[0..MAX_DEPTH-1] plus an internal active-length register len_q.
REQ-004 On a cycle with in_valid=1 and clear=0, the line SHALL advance: stage[0] takes in_data and stage[i] takes stage[i-1] for every i>0.
REQ-005 With in_valid=0, all stages, fill_cnt and len_q SHALL hold; there is no free-running shift.
REQ-006 out_data SHALL be combinational stage[len_q-1], so it equals the word accepted len_q accepts earlier.
REQ-007 out_valid SHALL be combinational (fill_cnt==len_q).
REQ-008 A cycle with in_valid=1 and out_valid=1 SHALL consume out_data; the word falls off the active line on that edge.
REQ-009 fill_cnt SHALL increment by 1 on each advance while below len_q and saturate at len_q; it SHALL never wrap.
REQ-010 Stages at index len_q or higher SHALL still shift but SHALL NOT affect any output.
REQ-011 When clear=1, on that edge: all stages SHALL become 0, fill_cnt SHALL become 0, and len_q SHALL load cfg_len if 1<=cfg_len<=MAX_DEPTH.
REQ-012 When clear=1 with cfg_len=0 or cfg_len>MAX_DEPTH, len_q SHALL load MAX_DEPTH and cfg_err SHALL set.
REQ-013 cfg_err SHALL clear only on a clear cycle that presents a legal cfg_len.
REQ-014 clear and in_valid in the same cycle: clear SHALL win and in_data SHALL be dropped, not stored.
REQ-015 cfg_len SHALL be sampled only on clear cycles; changes at any other time SHALL have no effect.
REQ-016 Latency from an accepted word to its appearance on out_data SHALL be exactly len_q further accepts, independent of idle cycles between them.
REQ-017 With len_q=1, out_data SHALL equal the previously accepted word, and out_valid SHALL be 1 after the first accept.

Reset
REQ-018 While rst=1, asynchronously: all stages SHALL be 0, fill_cnt SHALL be 0, len_q SHALL be MAX_DEPTH, cfg_err SHALL be 0.
REQ-019 As a result of reset, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-020 rst asserted mid-fill SHALL discard all content, and the first accept after release SHALL behave as fill_cnt=0.

Configuration
REQ-021 With macro LINE_DELAY_MIDTAP_EN defined:
- mid_data SHALL exist and equal stage[(len_q>>1)-1] when len_q>=2, else stage[0].
- mid_data SHALL be valid when fill_cnt>=(len_q>>1), using the same clamp.
REQ-022 Without LINE_DELAY_MIDTAP_EN, the mid_data port and its mux SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 Bench SHALL cover the following directed scenarios (stimulus -> required response):
- Reset; then clear with cfg_len=28 and push 0x1..0x1C continuously -> out_valid first high after the 28th accept, with out_data=0x1; push 0x1D -> out_data=0x2.
- cfg_len=4; push A,B with 5 idle cycles, then C,D -> fill_cnt=4, out_data=A after D, unchanged by the idle gaps.
- cfg_len=0, then cfg_len=31 (MAX_DEPTH=30) -> len_q=30 and cfg_err=1 in both cases; next clear with cfg_len=5 -> cfg_err=0.
- Fill with cfg_len=3, then clear+in_valid with in_data=0xFF -> fill_cnt=0, out_valid=0, and 0xFF never appears on out_data.
- Assert rst at fill_cnt=10 -> outputs 0 immediately; after release, push with cfg_len still 30 -> out_valid after 30 accepts.
- With LINE_DELAY_MIDTAP_EN and cfg_len=8, push 1..8 -> mid_data=5 and out_data=1; without the macro, the port is absent and the build passes.

Source files
------------

// File: rtl/cnn_line_delay.sv
// cnn_line_delay: programmable word delay line for CNN line buffering.
// A chain of MAX_DEPTH stages advances only on accepted words (in_valid).
// The active length len_q, loaded on clear, selects which stage drives
// out_data. Stages beyond len_q keep shifting but never reach an output.
// An illegal requested length falls back to MAX_DEPTH and raises the
// sticky cfg_err flag, which clears on the next clear with a legal length.
// Optional feature macro: LINE_DELAY_MIDTAP_EN adds the mid_data half-depth tap.
module cnn_line_delay #(
    parameter int DATA_W    = 128,
    parameter int MAX_DEPTH = 30,
    parameter int LEN_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [LEN_W-1:0]  fill_cnt,
`ifdef LINE_DELAY_MIDTAP_EN
    output logic              cfg_err,
    output logic [DATA_W-1:0] mid_data
`else
    output logic              cfg_err
`endif
);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_DEPTH);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [DATA_W-1:0] r_stage [MAX_DEPTH];
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_fill_cnt;
    logic              r_cfg_err;

    logic              w_len_legal;
    logic              w_fill_below;
    logic [DATA_W-1:0] w_out_data;

    // Decode whether the requested length can be loaded and whether fill may still grow.
    always_comb begin
        w_len_legal  = (cfg_len != LEN_ZERO) && (cfg_len <= LEN_MAX);
        w_fill_below = (r_fill_cnt < r_len_q);
    end

    // Delay chain: async reset, clear flushes to zero, accepted words shift one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_DEPTH; i++) begin
                r_stage[i] <= {DATA_W{1'b0}};
            end
        end else if (clear) begin
            // clear wins over in_valid, so the presented word is dropped
            for (int i = 0; i < MAX_DEPTH; i++) begin
                r_stage[i] <= {DATA_W{1'b0}};
            end
        end else if (in_valid) begin
            r_stage[0] <= in_data;
            for (int i = 1; i < MAX_DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end else begin
            // no accept: the whole chain holds
            for (int i = 0; i < MAX_DEPTH; i++) begin
                r_stage[i] <= r_stage[i];
            end
        end
    end

    // Control state: active length, saturating fill count and sticky config error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_q    <= LEN_MAX;
            r_fill_cnt <= LEN_ZERO;
            r_cfg_err  <= 1'b0;
        end else if (clear) begin
            r_fill_cnt <= LEN_ZERO;
            if (w_len_legal) begin
                r_len_q   <= cfg_len;
                r_cfg_err <= 1'b0;
            end else begin
                r_len_q   <= LEN_MAX;
                r_cfg_err <= 1'b1;
            end
        end else if (in_valid && w_fill_below) begin
            // count up to len_q, then saturate (never wraps)
            r_fill_cnt <= r_fill_cnt + LEN_ONE;
            r_len_q    <= r_len_q;
            r_cfg_err  <= r_cfg_err;
        end else begin
            r_fill_cnt <= r_fill_cnt;
            r_len_q    <= r_len_q;
            r_cfg_err  <= r_cfg_err;
        end
    end

    // Output tap: one-hot AND-OR select of stage[len_q-1]; len_q is always 1..MAX_DEPTH.
    always_comb begin
        w_out_data = {DATA_W{1'b0}};
        for (int i = 0; i < MAX_DEPTH; i++) begin
            w_out_data = w_out_data
                       | (r_stage[i] & {DATA_W{r_len_q == LEN_W'(i + 1)}});
        end
    end

`ifdef LINE_DELAY_MIDTAP_EN
    logic [LEN_W-1:0]  w_mid_len;
    logic [DATA_W-1:0] w_mid_data;

    // Half-depth tap: stage[(len_q>>1)-1], clamped to stage[0] for len_q below 2.
    // The tap holds meaningful data once fill_cnt reaches w_mid_len.
    always_comb begin
        w_mid_data = {DATA_W{1'b0}};
        if (r_len_q >= LEN_W'(2)) begin
            w_mid_len = r_len_q >> 1;
        end else begin
            w_mid_len = LEN_ONE;
        end
        for (int i = 0; i < MAX_DEPTH; i++) begin
            w_mid_data = w_mid_data
                       | (r_stage[i] & {DATA_W{w_mid_len == LEN_W'(i + 1)}});
        end
    end

    assign mid_data = w_mid_data;
`endif

    assign out_data  = w_out_data;
    assign out_valid = (r_fill_cnt == r_len_q);
    assign fill_cnt  = r_fill_cnt;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_cnn_line_delay.sv
// Self-checking bench for cnn_line_delay: queue-based history model,
// per-cycle negedge comparison, directed scenarios plus randomized traffic.
// Define LINE_DELAY_MIDTAP_EN to also exercise the mid_data tap.
module tb_cnn_line_delay;

    localparam int DW = 128;
    localparam int MD = 30;
    localparam int LW = 5;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          clear    = 1'b0;
    logic [LW-1:0] cfg_len  = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [LW-1:0] fill_cnt;
    logic          cfg_err;
`ifdef LINE_DELAY_MIDTAP_EN
    logic [DW-1:0] mid_data;
`endif

    cnn_line_delay #(.DATA_W(DW), .MAX_DEPTH(MD)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .fill_cnt (fill_cnt),
`ifdef LINE_DELAY_MIDTAP_EN
        .cfg_err  (cfg_err),
        .mid_data (mid_data)
`else
        .cfg_err  (cfg_err)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: words accepted since the last clear/reset, newest first.
    logic [DW-1:0] hist[$];
    int            m_len = MD;
    bit            m_err = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word accepted k+1 accepts ago, or 0 if not yet that many since flush.
    function automatic logic [DW-1:0] exp_stage(input int k);
        if (k < hist.size()) return hist[k];
        return '0;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_step(input bit c, input int l, input bit v, input logic [DW-1:0] d);
        if (c) begin
            hist.delete();
            if (l >= 1 && l <= MD) begin
                m_len = l;
                m_err = 1'b0;
            end else begin
                m_len = MD;
                m_err = 1'b1;
            end
        end else if (v) begin
            hist.push_front(d);
            if (hist.size() > MD) void'(hist.pop_back());
        end
    endtask

    // One clock: drive inputs, take the edge, advance model, settle.
    task automatic cycle(input bit c, input logic [LW-1:0] l, input bit v, input logic [DW-1:0] d);
        clear    = c;
        cfg_len  = l;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step(c, int'(l), v, d);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(1'b0, LW'($urandom_range(0, 31)), 1'b1, d);
    endtask

    task automatic idle();
        cycle(1'b0, LW'($urandom_range(0, 31)), 1'b0, rnd_word());
    endtask

    task automatic do_clear(input int l);
        cycle(1'b1, LW'(l), 1'b0, '0);
    endtask

    // Asynchronous reset: outputs must drop immediately, before any edge.
    task automatic do_reset();
        rst = 1'b1;
        hist.delete();
        m_len = MD;
        m_err = 1'b0;
        #1;
        chk("rst_out_data", out_data, '0);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_fill_cnt", DW'(fill_cnt), '0);
        chk("rst_cfg_err", DW'(cfg_err), '0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    // Every-cycle comparison against the history model.
    always @(negedge clk) begin
        if (chk_en) begin
            int ef;
            int ml;
            ef = (hist.size() < m_len) ? hist.size() : m_len;
            chk("cyc_fill_cnt", DW'(fill_cnt), DW'(ef));
            chk("cyc_out_valid", DW'(out_valid), DW'(ef == m_len));
            chk("cyc_out_data", out_data, exp_stage(m_len - 1));
            chk("cyc_cfg_err", DW'(cfg_err), DW'(m_err));
            ml = (m_len >= 2) ? (m_len / 2) : 1;
`ifdef LINE_DELAY_MIDTAP_EN
            chk("cyc_mid_data", mid_data, exp_stage(ml - 1));
`else
            if (ml < 1) $display("unexpected mid length %0d", ml);
`endif
        end
    end

    initial begin
        logic [DW-1:0] first;
        #3;
        do_reset();

        // Length 28, continuous push 1..28: valid exactly at the 28th accept.
        do_clear(28);
        for (int i = 1; i <= 28; i++) begin
            push(DW'(i));
            chk("s1_out_valid", DW'(out_valid), DW'(i == 28));
        end
        chk("s1_out_data_first", out_data, DW'(1));
        push(DW'(29));
        chk("s1_out_data_next", out_data, DW'(2));

        // Length 4 with idle gaps: latency counts accepts only.
        do_clear(4);
        push(DW'('hA));
        push(DW'('hB));
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("s2_idle_fill", DW'(fill_cnt), DW'(2));
        end
        push(DW'('hC));
        push(DW'('hD));
        chk("s2_fill", DW'(fill_cnt), DW'(4));
        chk("s2_out_data", out_data, DW'('hA));
        idle();
        chk("s2_out_hold", out_data, DW'('hA));

        // Illegal lengths fall back to 30 with sticky error; legal clear clears it.
        for (int t = 0; t < 2; t++) begin
            do_clear(t == 0 ? 0 : 31);
            chk("s3_cfg_err", DW'(cfg_err), DW'(1));
            for (int i = 1; i <= 30; i++) begin
                push(rnd_word());
                chk("s3_valid_at_30", DW'(out_valid), DW'(i == 30));
            end
        end
        do_clear(5);
        chk("s3_err_cleared", DW'(cfg_err), DW'(0));

        // clear together with in_valid: the word is dropped.
        do_clear(3);
        push(DW'(1)); push(DW'(2)); push(DW'(3));
        chk("s4_full", DW'(out_valid), DW'(1));
        cycle(1'b1, LW'(3), 1'b1, DW'('hFF));
        chk("s4_fill", DW'(fill_cnt), DW'(0));
        chk("s4_valid", DW'(out_valid), DW'(0));
        push(DW'(7)); push(DW'(8)); push(DW'(9));
        chk("s4_no_ff", out_data, DW'(7));

        // Reset mid-fill, then fill from scratch at length 30.
        do_clear(30);
        for (int i = 0; i < 10; i++) push(rnd_word());
        chk("s5_fill10", DW'(fill_cnt), DW'(10));
        do_reset();
        first = rnd_word();
        for (int i = 1; i <= 30; i++) begin
            push(i == 1 ? first : rnd_word());
            chk("s5_valid_at_30", DW'(out_valid), DW'(i == 30));
        end
        chk("s5_out_first", out_data, first);

`ifdef LINE_DELAY_MIDTAP_EN
        do_clear(8);
        for (int i = 1; i <= 8; i++) push(DW'(i));
        chk("s6_mid_data", mid_data, DW'(5));
        chk("s6_out_data", out_data, DW'(1));
`endif

        // Randomized traffic, biased toward short lengths.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 2) begin
                do_reset();
            end else if (r < 12) begin
                if ($urandom_range(0, 1) == 1) do_clear($urandom_range(1, 6));
                else do_clear($urandom_range(0, 31));
            end else if (r < 22) begin
                cycle(1'b1, LW'($urandom_range(0, 31)), 1'b1, rnd_word());
            end else if ($urandom_range(0, 99) < 70) begin
                push(rnd_word());
            end else begin
                idle();
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
